qspi_flash_resp: RTL
====================

Name: qspi_flash_resp

Overview:
- SPI-flash responder: the device end of the SoC's QSPI master link (sclk, cs_n, dq[3:0]).
- Emulates a minimal serial NOR flash, backed by an on-chip byte memory. Supports JEDEC ID, status, and read commands.
- Used for board bring-up and for closed-loop simulation of the SoC boot path without an external flash part.
- Oversamples the SPI pins on the system clock; no logic runs on qspi_clk itself.

Parameters:
- ADDR_W, 16: width of the backing-memory byte address; the 24-bit flash address is truncated to this width.
- JEDEC_ID, 24'hEF4018: the three bytes returned by command 0x9F, MSB first.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and dq inputs; legal values 2..3.

Ports:
- clk  in  1  system clock; must be at least 8x sclk.
- rst_n  in  1  synchronous reset, active low.
- spi_sclk_i  in  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
- spi_csn_i  in  1  chip select, active low.
- spi_sdi_i  in  4  dq inputs; dq[0] is MOSI in single mode.
- spi_sdo_o  out  4  dq outputs; dq[1] is MISO in single mode.
- spi_oen_o  out  4  per-line output enable, 1 = hi-z.
- status_i  in  8  byte returned by command 0x05.
- mem_rd_o  out  1  one-cycle read strobe to the backing memory.
- mem_addr_o  out  ADDR_W  backing-memory byte address.
- mem_rdata_i  in  8  read data, valid exactly one clk after mem_rd_o.
- busy_o  out  1  high while a transaction is in progress (cs_n low, synced).
- last_cmd_o  out  8  last command byte received.

Behaviour:
- Interface fixed: one clock (clk); synchronous active-low reset (rst_n). All flops update on clk rising edge only.
- Reset values: spi_sdo_o=0, spi_oen_o=4'hF, mem_rd_o=0, mem_addr_o=0, busy_o=0, last_cmd_o=0, state=IDLE.
- Input handling: inputs pass through SYNC_STAGES flops. A sclk rise/fall event is one clk pulse, detected from the last two synced samples. Sample on rise; drive on fall.
- Bit order: MSB first for command, address and data.
- States:
  - IDLE: synced cs_n falls -> CMD, bit counter = 0, busy_o = 1.
  - CMD: shift dq[0] on each rise. On the 8th rise latch last_cmd_o, then branch:
    - 0x03 -> ADDR.
    - 0x9F -> DATA with source ID, index 0.
    - 0x05 -> DATA with source STATUS.
    - 0x6B -> ADDR (only with QUAD_EN; see Optional Feature).
    - other -> IGNORE.
  - ADDR: 24 rises. On the 24th rise, issue mem_rd_o with mem_addr_o = addr[ADDR_W-1:0], then go to DATA (0x03) or DUMMY (0x6B).
  - DUMMY: 8 rises, then DATA.
  - DATA: on each fall drive the next bit of the current byte on dq[1], with spi_oen_o[1] = 0.
    - When bit 0 is driven: increment the address, pulse mem_rd_o, and load the next byte from mem_rdata_i one clk later.
    - ID source cycles through byte 2, 1, 0, then 2 again.
    - STATUS source repeats status_i, resampled at each byte start.
  - IGNORE: all outputs hi-z; remain until cs_n goes high.
- Address wrap: increment is modulo 2^ADDR_W (0xFFFF -> 0x0000 at the default width).
- First data bit: bit 7 is driven on the fall following the last address/dummy/command rise. For 0x05/0x9F the first byte is available combinationally from the source; for reads it comes from the read issued at the 24th rise.
- cs_n rise (synced), in any state: next clk go to IDLE, spi_oen_o = 4'hF, busy_o = 0, counters cleared; a byte in flight is discarded. This also covers reset of the transaction mid-operation.
- Simultaneous cs_n rise and sclk edge: cs_n takes priority; the edge is ignored.
- sclk edges while cs_n is high are ignored.
- rst_n low mid-transaction: return to IDLE with reset values. The first transaction after reset requires a fresh cs_n fall.

Optional Feature:
- Macro: QSPI_FLASH_RESP_QUAD_EN.
- Defined: command 0x6B (fast read quad output) is accepted.
  - Single-line command and address, then 8 dummy rises.
  - Data is driven on dq[3:0], 4 bits per fall, high nibble first, spi_oen_o = 4'h0. A byte takes 2 falls; the next read is issued on the low-nibble fall.
- Undefined: 0x6B is treated as unknown -> IGNORE; no quad datapath logic is present.

Test Plan:
- Reset, cs_n high, sclk toggling -> spi_oen_o=4'hF, busy_o=0, mem_rd_o never asserted.
- cs_n low, cmd 0x9F, 24 clocks -> MISO returns 0xEF,0x40,0x18; last_cmd_o=0x9F.
- cmd 0x03, addr 0x00FFFE, memory preloaded with 0xFFFE=0xA5, 0xFFFF=0x3C, 0x0000=0x7E, read 3 bytes -> 0xA5,0x3C,0x7E. Exactly one mem_rd_o per byte (plus the prefetch), showing wrap at 0xFFFF.
- cmd 0x05 with status_i=0x02, then status_i changed to 0x81 mid first byte -> bytes 0x02, 0x81.
- cmd 0x03, cs_n raised after 12 address bits, then cmd 0x9F -> no mem_rd_o from the aborted command; second command returns 0xEF first.
- cmd 0x6B, addr 0x000010, mem[0x10]=0x5A:
  - With QSPI_FLASH_RESP_QUAD_EN: after 8 dummy rises, nibbles 0x5,0xA appear on dq[3:0].
  - Without it: spi_oen_o stays 4'hF.

Source files
------------

// File: rtl/qspi_flash_resp.sv
// SPI-flash responder: minimal serial NOR flash (JEDEC ID, status, read) over an on-chip byte memory.
// Define QSPI_FLASH_RESP_QUAD_EN to also accept 0x6B (fast read, quad output).
`timescale 1ns/1ps
module qspi_flash_resp #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk_i,
  input  logic              spi_csn_i,
  input  logic [3:0]        spi_sdi_i,
  output logic [3:0]        spi_sdo_o,
  output logic [3:0]        spi_oen_o,
  input  logic [7:0]        status_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic [7:0]        last_cmd_o
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StIgnore} state_e;
  typedef enum logic [1:0] {SrcMem, SrcId, SrcStatus} src_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, sdi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  state_e              state_q, state_d;
  src_e                src_q, src_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-2:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   shift_in;
  logic [1:0]          id_idx_q, id_idx_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                rd_pend_q;
  logic [3:0]          sdo_q, sdo_d;
  logic [3:0]          oen_q, oen_d;
  logic [7:0]          last_cmd_q, last_cmd_d;
  logic [7:0]          id_byte, cur_byte;
`ifdef QSPI_FLASH_RESP_QUAD_EN
  logic                quad_q, quad_d;
  logic                nib_q, nib_d;
`endif

  // Only dq[0] is ever sampled; the upper lines are outputs in every supported mode.
  logic unused_sdi;
  assign unused_sdi = ^spi_sdi_i[3:1];

  // Sync regs reset low so a cs_n held low through reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i[0]};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign shift_in  = {shift_q, sdi_s};

  always_comb begin
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  // ID and status bytes are taken live at byte start; memory bytes come from the loaded register.
  always_comb begin
    unique case (src_q)
      SrcId:     cur_byte = id_byte;
      SrcStatus: cur_byte = status_i;
      default:   cur_byte = data_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    id_idx_d   = id_idx_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    addr_d     = addr_q;
    mem_rd_d   = 1'b0;
    sdo_d      = sdo_q;
    oen_d      = oen_q;
    last_cmd_d = last_cmd_q;
`ifdef QSPI_FLASH_RESP_QUAD_EN
    quad_d     = quad_q;
    nib_d      = nib_q;
`endif
    if (rd_pend_q) data_d = mem_rdata_i;

    if (csn_rise) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      bit_idx_d = 3'd7;
      id_idx_d  = '0;
      sdo_d     = '0;
      oen_d     = 4'hF;
`ifdef QSPI_FLASH_RESP_QUAD_EN
      quad_d    = 1'b0;
      nib_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (csn_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            shift_d   = shift_in[ADDR_W-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = '0;
              bit_idx_d  = 3'd7;
              id_idx_d   = '0;
              last_cmd_d = shift_in[7:0];
              case (shift_in[7:0])
                8'h03: begin
                  state_d = StAddr;
                  src_d   = SrcMem;
                end
                8'h9F: begin
                  state_d = StData;
                  src_d   = SrcId;
                end
                8'h05: begin
                  state_d = StData;
                  src_d   = SrcStatus;
                end
`ifdef QSPI_FLASH_RESP_QUAD_EN
                8'h6B: begin
                  state_d = StAddr;
                  src_d   = SrcMem;
                  quad_d  = 1'b1;
                end
`endif
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            shift_d   = shift_in[ADDR_W-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              addr_d    = shift_in;
              mem_rd_d  = 1'b1;
`ifdef QSPI_FLASH_RESP_QUAD_EN
              state_d   = quad_q ? StDummy : StData;
`else
              state_d   = StData;
`endif
            end
          end
        end
        StDummy: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = StData;
            end
          end
        end
        StData: begin
          if (sclk_fall) begin
`ifdef QSPI_FLASH_RESP_QUAD_EN
            if (quad_q) begin
              oen_d = 4'h0;
              nib_d = ~nib_q;
              if (!nib_q) begin
                sdo_d = data_q[7:4];
              end else begin
                sdo_d    = data_q[3:0];
                addr_d   = addr_q + 1'b1;
                mem_rd_d = 1'b1;
              end
            end else
`endif
            begin
              oen_d     = 4'b1101;
              sdo_d     = {2'b00, (bit_idx_q == 3'd7) ? cur_byte[7] : data_q[bit_idx_q], 1'b0};
              bit_idx_d = bit_idx_q - 3'd1;
              if (bit_idx_q == 3'd7 && src_q != SrcMem) data_d = cur_byte;
              if (bit_idx_q == 3'd0) begin
                if (src_q == SrcMem) begin
                  addr_d   = addr_q + 1'b1;
                  mem_rd_d = 1'b1;
                end
                if (src_q == SrcId) id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
              end
            end
          end
        end
        StIgnore: oen_d = 4'hF;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= SrcMem;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      id_idx_q   <= '0;
      bit_idx_q  <= 3'd7;
      data_q     <= '0;
      addr_q     <= '0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      sdo_q      <= '0;
      oen_q      <= 4'hF;
      last_cmd_q <= '0;
`ifdef QSPI_FLASH_RESP_QUAD_EN
      quad_q     <= 1'b0;
      nib_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      id_idx_q   <= id_idx_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_pend_q  <= mem_rd_q;
      sdo_q      <= sdo_d;
      oen_q      <= oen_d;
      last_cmd_q <= last_cmd_d;
`ifdef QSPI_FLASH_RESP_QUAD_EN
      quad_q     <= quad_d;
      nib_q      <= nib_d;
`endif
    end
  end

  assign spi_sdo_o  = sdo_q;
  assign spi_oen_o  = oen_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != StIdle);
  assign last_cmd_o = last_cmd_q;

endmodule
